pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register replacing per-stage hand-built latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined datapath.
- Carries a data bundle and a control bundle between stages with a valid/ready handshake.
- Supports an optional 2-entry skid buffer, synchronous flush (bubble insertion) that zeroes control bits, global stall freeze, and a saturating backpressure counter for performance debug.

---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/pipe_stage_if.sv | 34 +++
 rtl/pipe_entry_reg.sv | 35 +++
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_reg.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: control bundle layout, bubble constant and per-stage data bundles.
package cpu_types_pkg;

    localparam int unsigned PIPE_CTRL_W = 16;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned REG_ADDR_W  = 5;

    // Control bundle; all-zero is a bubble (no side effects downstream).
    typedef struct packed {
        logic       reg_wen;
        logic       dmem_wen;
        logic       dmem_ren;
        logic       halt;
        logic [1:0] wb_sel;
        logic [1:0] pc_sel;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       jump;
        logic       lui;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_BUBBLE = '0;

    typedef struct packed {
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] instr;
    } if_id_data_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] imm;
    } id_ex_data_t;

    typedef struct packed {
        logic [WORD_W-1:0]     pc4;
        logic [WORD_W-1:0]     alu_out;
        logic [WORD_W-1:0]     rdat2;
        logic [REG_ADDR_W-1:0] wsel;
    } ex_mem_data_t;

    typedef struct packed {
        logic [WORD_W-1:0]     pc4;
        logic [WORD_W-1:0]     alu_out;
        logic [WORD_W-1:0]     dload;
        logic [REG_ADDR_W-1:0] wsel;
    } mem_wb_data_t;

    localparam int unsigned PIPE_DATA_W = $bits(id_ex_data_t);

endpackage

// File: rtl/pipe_stage_if.sv
// Bundled view of a pipeline stage boundary; stage side drives out_*/in_ready.
interface pipe_stage_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input logic CLK,
    input logic nRST
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              stall;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bp_count;

    modport stage (
        input  CLK, nRST, in_valid, in_data, in_ctrl, out_ready, flush, stall,
        output in_ready, out_valid, out_data, out_ctrl, occupancy, bp_count
    );

    modport tb (
        input  CLK, nRST, in_ready, out_valid, out_data, out_ctrl, occupancy, bp_count,
        output in_valid, in_data, in_ctrl, out_ready, flush, stall
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// One valid+data+ctrl storage slot; flush kills the entry and zeroes ctrl but keeps data.
module pipe_entry_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic              clear,
    input  logic              flush,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end else if (clear) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid, flush, stall
// and a saturating backpressure counter.
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stall,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_count
);

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic              skid_valid;
    logic              head_load;
    logic              head_clear;
    logic [DATA_W-1:0] head_d_data;
    logic [CTRL_W-1:0] head_d_ctrl;
    logic              in_fire;
    logic              out_fire;

    // Stall presents a bubble downstream; in_ready already folds in ~stall.
    assign out_valid = head_valid & ~stall;
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_data  = head_data;
    assign out_ctrl  = out_valid ? head_ctrl : CTRL_W'(0);
    assign occupancy = 2'(head_valid) + 2'(skid_valid);

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
        .CLK     (CLK),
        .nRST    (nRST),
        .load    (head_load),
        .clear   (head_clear),
        .flush   (flush),
        .d_data  (head_d_data),
        .d_ctrl  (head_d_ctrl),
        .q_valid (head_valid),
        .q_data  (head_data),
        .q_ctrl  (head_ctrl)
    );

    if (SKID != 0) begin : g_skid
        logic [DATA_W-1:0] skid_data;
        logic [CTRL_W-1:0] skid_ctrl;
        logic              skid_load;

        // Ready depends only on registered skid state, never on out_ready.
        assign in_ready    = ~skid_valid & ~stall;
        assign head_load   = (out_fire & skid_valid) | (in_fire & (~head_valid | out_fire));
        assign head_clear  = out_fire;
        assign head_d_data = skid_valid ? skid_data : in_data;
        assign head_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
        assign skid_load   = in_fire & head_valid & ~out_fire;

        pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .CLK     (CLK),
            .nRST    (nRST),
            .load    (skid_load),
            .clear   (out_fire),
            .flush   (flush),
            .d_data  (in_data),
            .d_ctrl  (in_ctrl),
            .q_valid (skid_valid),
            .q_data  (skid_data),
            .q_ctrl  (skid_ctrl)
        );
    end else begin : g_single
        assign in_ready    = (~head_valid | out_ready) & ~stall;
        assign head_load   = in_fire;
        assign head_clear  = out_fire;
        assign head_d_data = in_data;
        assign head_d_ctrl = in_ctrl;
        assign skid_valid  = 1'b0;
    end

    // Backpressure cycles: head held, not stalled, downstream not ready; sticks at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bp_count <= '0;
        end else if (head_valid && !stall && !out_ready && !(&bp_count)) begin
            bp_count <= bp_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Checks a skid (index 1) and a single-register (index 0) stage against a queue model.
module tb_pipe_stage_reg;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned NW = 4;
    localparam int BP_MAX = 15;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;

    logic          in_ready [2];
    logic          out_valid [2];
    logic [DW-1:0] out_data [2];
    logic [CW-1:0] out_ctrl [2];
    logic [1:0]    occupancy [2];
    logic [NW-1:0] bp_count [2];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) dut0 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
        .flush(flush), .stall(stall), .occupancy(occupancy[0]), .bp_count(bp_count[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut1 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
        .flush(flush), .stall(stall), .occupancy(occupancy[1]), .bp_count(bp_count[1])
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Reference model: FIFO contents (capacity 1 or 2) and backpressure count per instance.
    ent_t mbuf [2][2];
    int   cnt [2];
    int   bp_m [2];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s skid=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            cnt[k]  = 0;
            bp_m[k] = 0;
        end
    endtask

    // Drive one cycle of inputs, check both instances, then advance the model past the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl, input logic st);
        logic e_ir;
        logic e_ov;
        logic ifire;
        logic ofire;
        ent_t e;
        @(negedge CLK);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; stall = st;
        #1;
        e.d = d;
        e.c = c;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) e_ir = (cnt[k] < 2) && !st;
            else        e_ir = (cnt[k] == 0 || ordy) && !st;
            e_ov = (cnt[k] > 0) && !st;
            chk("in_ready", k, 64'(in_ready[k]), 64'(e_ir));
            chk("out_valid", k, 64'(out_valid[k]), 64'(e_ov));
            chk("out_ctrl", k, 64'(out_ctrl[k]), e_ov ? 64'(mbuf[k][0].c) : 64'd0);
            if (e_ov) chk("out_data", k, 64'(out_data[k]), 64'(mbuf[k][0].d));
            chk("occupancy", k, 64'(occupancy[k]), 64'(cnt[k]));
            chk("bp_count", k, 64'(bp_count[k]), 64'(bp_m[k]));

            ifire = v && e_ir && !fl;
            ofire = e_ov && ordy;
            if (cnt[k] > 0 && !st && !ordy && bp_m[k] < BP_MAX) bp_m[k]++;
            if (fl) begin
                cnt[k] = 0;
            end else if (!st) begin
                if (ofire) begin
                    mbuf[k][0] = mbuf[k][1];
                    cnt[k]--;
                end
                if (ifire) begin
                    mbuf[k][cnt[k]] = e;
                    cnt[k]++;
                end
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges must clear every output without waiting for a clock.
    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, 64'(out_valid[k]), 64'd0);
            chk("rst_out_data", k, 64'(out_data[k]), 64'd0);
            chk("rst_out_ctrl", k, 64'(out_ctrl[k]), 64'd0);
            chk("rst_occupancy", k, 64'(occupancy[k]), 64'd0);
            chk("rst_bp_count", k, 64'(bp_count[k]), 64'd0);
        end
    endtask

    task automatic reset_midstream();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        check_reset_outputs();
        @(negedge CLK);
        nRST = 1'b1;

        // Single transfer, 1-cycle latency.
        step(1'b1, 32'h1234, 16'h0005, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure fill then drain in order.
        step(1'b1, 32'hAAAA_0001, 16'h00A1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 16'h00B2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hCCCC_0003, 16'h00C3, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with a full stage and a new entry offered.
        step(1'b1, 32'h1111_0001, 16'h0011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2222_0002, 16'h0022, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3333_0003, 16'h0033, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Stall freezes a valid head for 3 cycles, then it emits.
        step(1'b1, 32'hD00D_0004, 16'h0D04, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hEEEE_0000, 16'h0E00, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Back-to-back streaming.
        for (int i = 0; i < 8; i++) step(1'b1, DW'(32'h5000 + i), CW'(16'h100 + i), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Counter saturation under long backpressure.
        step(1'b1, 32'hF00D_0005, 16'h0F05, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);

        // Reset asserted with entries held.
        step(1'b1, 32'h0BAD_0006, 16'h0B06, 1'b0, 1'b0, 1'b0);
        reset_midstream();

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0);
            if (i == 200) reset_midstream();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
